ika_slot_timinggen: RTL and testbench
=====================================

// Module: ika_slot_timinggen
// PURPOSE
//  Parametrised operator-slot timing generator for the IKA FM cores. Synchronises chip reset,
//  derives phi1 and its emulation clock enables from the phiM enable, and runs an N-slot
//  counter. It produces SH1/SH2, runtime-programmable slot strobes, a frame counter and an
//  external resync input. It sits at the top of each core and feeds every slot-sequenced block.
// PARAMETERS
//  SLOTS     32  slots per frame; power of two, 4..256; CW = $clog2(SLOTS)
//  NSTB      4   number of programmable slot strobes, 1..16
//  SH_DELAY  5   SH1/SH2 delay in phi1 cycles, 1..8
//  FRAME_W   8   frame counter width
//  SYNC_SLOT 0   slot value loaded on an external resync
// PORTS
//  i_EMUCLK       in   1          emulator master clock; all flops on posedge
//  i_IC_n         in   1          chip reset; asynchronous assert, active-low
//  i_phiM_PCEN_n  in   1          phiM clock enable, active-low
//  i_SYNC_n       in   1          external resync; active on a falling edge
//  i_STB_SLOT     in   NSTB*CW    strobe k compare value at [k*CW +: CW]
//  o_MRST_n       out  1          core internal reset
//  o_phi1         out  1          phi1 = phiM/2
//  o_phi1_PCEN_n  out  1          phi1 positive-edge enable, active-low
//  o_phi1_NCEN_n  out  1          phi1 negative-edge enable, active-low
//  o_SLOT         out  CW         current slot counter
//  o_SH1, o_SH2   out  1          sample/hold strobes
//  o_STB          out  NSTB       programmable slot strobes
//  o_FRAME_START  out  1          one phi1 cycle pulse at slot 0
//  o_FRAME_CNT    out  FRAME_W    frame counter
// BEHAVIOUR
//  Reset and clock
//  - One clock, i_EMUCLK. Reset is asynchronous and active-low on i_IC_n.
//  - While i_IC_n=0, all flops clear immediately:
//    ic_sync=00, phi1p=1, o_MRST_n=0, slot=0, frame=0; o_SH1/o_SH2/o_STB/o_FRAME_START=0.
//  Reset release
//  - i_IC_n passes through a 2-stage synchroniser clocked on phiM enables (ic_sync[1:0]).
//  - While ic_sync[1]=0: phi1p is held at 1.
//  - Once ic_sync[1]=1: phi1p toggles on every phiM enable.
//  Clock enables
//  - PCEN_n = phi1p | i_phiM_PCEN_n.
//  - NCEN_n = ~phi1p | i_phiM_PCEN_n | ~ic_sync[1].
//  - All logic below updates only on NCEN (NCEN_n=0).
//  Core reset
//  - o_MRST_n <= ic_sync[1] on each NCEN.
//  - Deassertion therefore lands on the first NCEN after synchronised release.
//  Slot counter, priority high to low
//  - o_MRST_n=0 -> slot=0.
//  - Resync edge pending -> slot=SYNC_SLOT.
//  - Otherwise slot=slot+1, wrapping from SLOTS-1 to 0.
//  Resync
//  - i_SYNC_n is sampled on NCEN into s0/s1; an edge means s1=1 and s0=0.
//  - Slot reload takes effect one NCEN after the edge is detected.
//  - Edges detected while o_MRST_n=0 are discarded.
//  Frame counter
//  - frame+1 only on a natural wrap (SLOTS-1 -> 0); wraps modulo 2^FRAME_W.
//  - A resync load never increments it, even when SYNC_SLOT=0.
//  - o_FRAME_START is registered: 1 for the phi1 cycle after the counter enters 0 by any path.
//  Strobes
//  - o_STB[k] <= (slot == i_STB_SLOT[k]) on each NCEN; latency is one phi1 cycle.
//  - i_STB_SLOT may change at any time; the new value applies from the next NCEN.
//  SH1/SH2
//  - raw sh1 = slot[CW-1:CW-2]==2'b11; raw sh2 = slot[CW-1:CW-2]==2'b01.
//  - Each passes through an SH_DELAY-stage shift register on NCEN, then an output register.
//  - Total latency from slot to pin is SH_DELAY+1 phi1 cycles.
//  - The output register is forced to 0 while o_MRST_n=0.
//  Reset mid-operation
//  - Pulling i_IC_n low mid-frame returns every output to its reset value at once; no partial frame.
// TESTING
//  T1 Reset release: hold i_IC_n=0 for 8 phiM, then release.
//     -> o_MRST_n rises on the first NCEN after ic_sync[1]=1.
//     -> slot reads 0,1,2,... from then on.
//  T2 Wrap (SLOTS=32, then SLOTS=64): run 3 frames.
//     -> slot wraps 31->0 (63->0); o_FRAME_CNT reads 0,1,2.
//     -> o_FRAME_START pulses once per frame.
//  T3 Strobes: set i_STB_SLOT = {5,12,21,28}.
//     -> o_STB[k] is high exactly one phi1 cycle, one cycle after slot equals each value.
//  T4 Resync: SYNC_SLOT=0, drive i_SYNC_n low at slot 17.
//     -> slot becomes 0 two NCENs later.
//     -> o_FRAME_CNT does not increment; o_FRAME_START pulses.
//  T5 SH delay (SH_DELAY=5 and SH_DELAY=1):
//     -> o_SH1 is high for 8 cycles, starting 6 (2) cycles after slot 24.
//     -> o_SH2 behaves the same relative to slot 8.
//  T6 Reset mid-frame: drop i_IC_n asynchronously (not on a clock edge) at slot 26.
//     -> all outputs reach reset values with no clock edge required.
//     -> behaviour after release matches T1.

Source files
------------

// File: rtl/ika_slot_timinggen_if.sv
// Slot timing bundle: phiM enable, resync and strobe compare values in, phi1 timing and slot strobes out.
// Latency: n/a (wires only).
// Backpressure: none; every consumer samples the strobes on its own phi1 enables.
interface ika_slot_timinggen_if #(
    parameter int SLOTS   = 32,
    parameter int NSTB    = 4,
    parameter int FRAME_W = 8
);
    localparam int CW = $clog2(SLOTS);

    // inputs to the timing generator
    logic                 i_phiM_PCEN_n;
    logic                 i_SYNC_n;
    logic [NSTB*CW-1:0]   i_STB_SLOT;

    // outputs of the timing generator
    logic                 o_MRST_n;
    logic                 o_phi1;
    logic                 o_phi1_PCEN_n;
    logic                 o_phi1_NCEN_n;
    logic [CW-1:0]        o_SLOT;
    logic                 o_SH1;
    logic                 o_SH2;
    logic [NSTB-1:0]      o_STB;
    logic                 o_FRAME_START;
    logic [FRAME_W-1:0]   o_FRAME_CNT;

    // the timing generator itself
    modport master (
        input  i_phiM_PCEN_n, i_SYNC_n, i_STB_SLOT,
        output o_MRST_n, o_phi1, o_phi1_PCEN_n, o_phi1_NCEN_n, o_SLOT,
               o_SH1, o_SH2, o_STB, o_FRAME_START, o_FRAME_CNT
    );

    // the driving environment / slot-sequenced consumers
    modport slave (
        output i_phiM_PCEN_n, i_SYNC_n, i_STB_SLOT,
        input  o_MRST_n, o_phi1, o_phi1_PCEN_n, o_phi1_NCEN_n, o_SLOT,
               o_SH1, o_SH2, o_STB, o_FRAME_START, o_FRAME_CNT
    );
endinterface

// File: rtl/ika_slot_timinggen.sv
// Operator-slot timing generator: reset sync, phi1 enables, slot/frame counters, SH1/SH2 and slot strobes.
// Latency: slot strobes 1 phi1 cycle after the slot; SH1/SH2 SH_DELAY+1 phi1 cycles after the slot.
// Backpressure: none; free-running on phiM enables, halted only by i_IC_n.
module ika_slot_timinggen #(
    parameter int SLOTS     = 32,
    parameter int NSTB      = 4,
    parameter int SH_DELAY  = 5,
    parameter int FRAME_W   = 8,
    parameter int SYNC_SLOT = 0
) (
    input  logic                  i_EMUCLK,
    input  logic                  i_IC_n,
    ika_slot_timinggen_if.master  io_bus
);
    localparam int            CW       = $clog2(SLOTS);
    localparam logic [CW-1:0] SLOT_MAX = CW'(SLOTS - 1);
    localparam logic [CW-1:0] SYNC_VAL = CW'(SYNC_SLOT);

    // ---------------------------------------------------------------
    // Reset synchroniser and phi1 generation
    // ---------------------------------------------------------------
    logic       w_phim_en;
    logic [1:0] r_ic_sync;
    logic       r_phi1p;
    logic       w_pcen_n;
    logic       w_ncen_n;
    logic       w_ncen;

    assign w_phim_en = ~io_bus.i_phiM_PCEN_n;

    // two-stage release synchroniser for i_IC_n, stepped on phiM enables
    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            r_ic_sync <= 2'b00;
        end else if (w_phim_en) begin
            r_ic_sync <= {r_ic_sync[0], 1'b1};
        end
    end

    // phi1 = phiM/2, parked high until the synchronised reset releases
    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            r_phi1p <= 1'b1;
        end else if (w_phim_en) begin
            r_phi1p <= r_ic_sync[1] ? ~r_phi1p : 1'b1;
        end
    end

    // The negative-edge enable is also gated by the synchroniser so nothing
    // downstream moves before the release has been seen on both stages.
    assign w_pcen_n = r_phi1p | io_bus.i_phiM_PCEN_n;
    assign w_ncen_n = ~r_phi1p | io_bus.i_phiM_PCEN_n | ~r_ic_sync[1];
    assign w_ncen   = ~w_ncen_n;

    // ---------------------------------------------------------------
    // Core reset, resync detector, slot and frame counters
    // ---------------------------------------------------------------
    logic               r_mrst_n;
    logic               r_sync_s0;
    logic               r_sync_s1;
    logic               w_sync_edge;
    logic [CW-1:0]      r_slot;
    logic [FRAME_W-1:0] r_frame;
    logic               r_frame_start;
    logic [CW-1:0]      w_slot_nxt;
    logic [FRAME_W-1:0] w_frame_nxt;
    logic               w_enter0;

    // core reset follows the synchroniser output, one phi1 step behind it
    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            r_mrst_n <= 1'b0;
        end else if (w_ncen) begin
            r_mrst_n <= r_ic_sync[1];
        end
    end

    // sample the resync pin; idle-high reset value avoids a false edge on release
    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            r_sync_s0 <= 1'b1;
            r_sync_s1 <= 1'b1;
        end else if (w_ncen) begin
            r_sync_s0 <= io_bus.i_SYNC_n;
            r_sync_s1 <= r_sync_s0;
        end
    end

    // falling edge on the resync pin, as seen by the two sample stages
    assign w_sync_edge = r_sync_s1 & ~r_sync_s0;

    // next slot/frame: core reset beats resync beats the natural increment
    always_comb begin
        w_slot_nxt  = r_slot;
        w_frame_nxt = r_frame;
        w_enter0    = 1'b0;
        if (!r_mrst_n) begin
            // leaving core reset counts as entering slot 0; any edge seen now is dropped
            w_slot_nxt = '0;
            w_enter0   = 1'b1;
        end else if (w_sync_edge) begin
            // a resync load never advances the frame counter
            w_slot_nxt = SYNC_VAL;
            w_enter0   = (SYNC_VAL == '0);
        end else if (r_slot == SLOT_MAX) begin
            w_slot_nxt  = '0;
            w_frame_nxt = r_frame + 1'b1;
            w_enter0    = 1'b1;
        end else begin
            w_slot_nxt = r_slot + 1'b1;
        end
    end

    // slot, frame and frame-start registers, advanced once per phi1 cycle
    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            r_slot        <= '0;
            r_frame       <= '0;
            r_frame_start <= 1'b0;
        end else if (w_ncen) begin
            r_slot        <= w_slot_nxt;
            r_frame       <= w_frame_nxt;
            r_frame_start <= w_enter0;
        end
    end

    // ---------------------------------------------------------------
    // Programmable slot strobes
    // ---------------------------------------------------------------
    logic [NSTB-1:0] w_stb_hit;
    logic [NSTB-1:0] r_stb;

    // compare the current slot against every strobe's programmed value
    always_comb begin
        w_stb_hit = '0;
        for (int k = 0; k < NSTB; k++) begin
            w_stb_hit[k] = (r_slot == io_bus.i_STB_SLOT[k*CW +: CW]);
        end
    end

    // register the matches so each strobe lands one phi1 cycle after its slot
    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            r_stb <= '0;
        end else if (w_ncen) begin
            r_stb <= w_stb_hit;
        end
    end

    // ---------------------------------------------------------------
    // SH1/SH2 sample-hold strobes
    // ---------------------------------------------------------------
    logic                w_sh1_raw;
    logic                w_sh2_raw;
    logic [SH_DELAY-1:0] r_sh1_sr;
    logic [SH_DELAY-1:0] r_sh2_sr;
    logic                r_sh1;
    logic                r_sh2;

    // SH1 covers the last quarter of the frame, SH2 the second quarter
    assign w_sh1_raw = (r_slot[CW-1:CW-2] == 2'b11);
    assign w_sh2_raw = (r_slot[CW-1:CW-2] == 2'b01);

    // SH_DELAY-deep delay line followed by an output register held low in core reset
    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            r_sh1_sr <= '0;
            r_sh2_sr <= '0;
            r_sh1    <= 1'b0;
            r_sh2    <= 1'b0;
        end else if (w_ncen) begin
            r_sh1_sr[0] <= w_sh1_raw;
            r_sh2_sr[0] <= w_sh2_raw;
            for (int i = 1; i < SH_DELAY; i++) begin
                r_sh1_sr[i] <= r_sh1_sr[i-1];
                r_sh2_sr[i] <= r_sh2_sr[i-1];
            end
            r_sh1 <= r_mrst_n & r_sh1_sr[SH_DELAY-1];
            r_sh2 <= r_mrst_n & r_sh2_sr[SH_DELAY-1];
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign io_bus.o_MRST_n      = r_mrst_n;
    assign io_bus.o_phi1        = r_phi1p;
    assign io_bus.o_phi1_PCEN_n = w_pcen_n;
    assign io_bus.o_phi1_NCEN_n = w_ncen_n;
    assign io_bus.o_SLOT        = r_slot;
    assign io_bus.o_SH1         = r_sh1;
    assign io_bus.o_SH2         = r_sh2;
    assign io_bus.o_STB         = r_stb;
    assign io_bus.o_FRAME_START = r_frame_start;
    assign io_bus.o_FRAME_CNT   = r_frame;

endmodule

// File: tb/tb_ika_slot_timinggen.sv
// Bench for ika_slot_timinggen: two instances (32 slots/SH delay 5, 64 slots/SH delay 1) on shared stimulus.
// Expected per-phi1-cycle output tuples are pushed before each NCEN and popped after it.
// Covers reset, release, wraps, strobes (incl. runtime change), SH delay, resync and async mid-frame reset.
module tb_ika_slot_timinggen;
    logic clk = 1'b0;
    logic ic_n;
    logic pm_n;
    logic sync_n;
    logic [19:0] stb_a;
    logic [23:0] stb_b;

    int n_chk = 0;
    int n_err = 0;
    int g_rs;
    int g_chg;
    int stb_old[4];
    int stb_new[4];
    int pcen_seen;
    logic [2:0] g_ph;
    logic [23:0] q_a[$];
    logic [23:0] q_b[$];

    ika_slot_timinggen_if #(.SLOTS(32), .NSTB(4), .FRAME_W(8)) bus_a ();
    ika_slot_timinggen_if #(.SLOTS(64), .NSTB(4), .FRAME_W(8)) bus_b ();

    assign bus_a.i_phiM_PCEN_n = pm_n;
    assign bus_a.i_SYNC_n      = sync_n;
    assign bus_a.i_STB_SLOT    = stb_a;
    assign bus_b.i_phiM_PCEN_n = pm_n;
    assign bus_b.i_SYNC_n      = sync_n;
    assign bus_b.i_STB_SLOT    = stb_b;

    ika_slot_timinggen #(.SLOTS(32), .NSTB(4), .SH_DELAY(5), .FRAME_W(8), .SYNC_SLOT(0)) u_dut_a (
        .i_EMUCLK (clk),
        .i_IC_n   (ic_n),
        .io_bus   (bus_a)
    );

    ika_slot_timinggen #(.SLOTS(64), .NSTB(4), .SH_DELAY(1), .FRAME_W(8), .SYNC_SLOT(0)) u_dut_b (
        .i_EMUCLK (clk),
        .i_IC_n   (ic_n),
        .io_bus   (bus_b)
    );

    logic [23:0] got_a;
    logic [23:0] got_b;
    assign got_a = {bus_a.o_MRST_n, 8'(bus_a.o_SLOT), bus_a.o_FRAME_CNT, bus_a.o_STB,
                    bus_a.o_SH1, bus_a.o_SH2, bus_a.o_FRAME_START};
    assign got_b = {bus_b.o_MRST_n, 8'(bus_b.o_SLOT), bus_b.o_FRAME_CNT, bus_b.o_STB,
                    bus_b.o_SH1, bus_b.o_SH2, bus_b.o_FRAME_START};

    initial forever #5 clk = ~clk;

    // phiM enable every other EMUCLK, changed just after the rising edge
    initial begin
        pm_n = 1'b1;
        forever begin
            @(posedge clk);
            #1 pm_n = ~pm_n;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_stb(input int v0, input int v1, input int v2, input int v3);
        stb_a = {5'(v3), 5'(v2), 5'(v1), 5'(v0)};
        stb_b = {6'(v3), 6'(v2), 6'(v1), 6'(v0)};
    endtask

    // slot in phi1 cycle n (n = 0 is the cycle o_MRST_n first reads 1)
    function automatic int slot_at(input int n, input int s);
        if (n < 0)     return 0;
        if (n < g_rs)  return n % s;
        return (n - g_rs) % s;
    endfunction

    function automatic int frame_at(input int n, input int s);
        if (n < g_rs) return (n / s) % 256;
        return ((g_rs - 1) / s + (n - g_rs) / s) % 256;
    endfunction

    function automatic logic [23:0] exp_vec(input int n, input int s, input int d, input int qsh);
        logic [3:0] stb;
        int v;
        int m;
        int top;
        for (int k = 0; k < 4; k++) begin
            v = (n >= g_chg) ? stb_new[k] : stb_old[k];
            stb[k] = (slot_at(n - 1, s) == v);
        end
        m   = n - d - 1;
        top = (m < 0) ? 0 : (slot_at(m, s) >> qsh);
        return {1'b1, 8'(slot_at(n, s)), 8'(frame_at(n, s)), stb,
                (top == 3), (top == 1), (slot_at(n, s) == 0)};
    endfunction

    // wait for the next phi1 NCEN, then sample on the following falling edge
    task automatic next_ncen(output bit ok);
        ok = 1'b0;
        pcen_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_a.o_phi1_PCEN_n == 1'b0) pcen_seen++;
            if (bus_a.o_phi1_NCEN_n == 1'b0) begin
                g_ph = {bus_a.o_phi1, bus_a.o_phi1_PCEN_n, bus_b.o_phi1_NCEN_n};
                ok = 1'b1;
                break;
            end
        end
        if (ok) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_a"}, got_a, 24'h0);
        check_val({tag, "_b"}, got_b, 24'h0);
        check_val({tag, "_clk_a"}, {bus_a.o_phi1, bus_a.o_phi1_PCEN_n, bus_a.o_phi1_NCEN_n}, 3'b111);
        check_val({tag, "_clk_b"}, {bus_b.o_phi1, bus_b.o_phi1_PCEN_n, bus_b.o_phi1_NCEN_n}, 3'b111);
    endtask

    task automatic run_cycles(input int first, input int last);
        bit ok;
        for (int n = first; n <= last; n++) begin
            if (n == g_chg)    set_stb(stb_new[0], stb_new[1], stb_new[2], stb_new[3]);
            if (n == g_rs - 1) sync_n = 1'b0;
            if (n == g_rs + 4) sync_n = 1'b1;
            q_a.push_back(exp_vec(n, 32, 5, 3));
            q_b.push_back(exp_vec(n, 64, 1, 4));
            next_ncen(ok);
            if (!ok) begin
                check_val("ncen_timeout", 32'd0, 32'd1);
                return;
            end
            check_val($sformatf("phase n%0d", n), 32'(g_ph), 32'h6);
            check_val($sformatf("pcen_cnt n%0d", n), pcen_seen, (n == 0) ? 0 : 1);
            check_val($sformatf("A n%0d", n), got_a, q_a.pop_front());
            check_val($sformatf("B n%0d", n), got_b, q_b.pop_front());
        end
    endtask

    initial begin
        ic_n   = 1'b1;
        sync_n = 1'b1;
        stb_old = '{5, 12, 21, 28};
        stb_new = '{0, 31, 1, 16};
        set_stb(stb_old[0], stb_old[1], stb_old[2], stb_old[3]);
        g_rs  = 100000;
        g_chg = 100000;

        // power-on reset, 8 phiM periods
        #2 ic_n = 1'b0;
        #1 check_reset("rst0");
        repeat (16) @(posedge clk);
        #3 check_reset("rst_hold");
        ic_n = 1'b1;

        // free run: 3+ frames of the 64-slot instance, strobe reprogram at cycle 100,
        // stopping with the 32-slot instance at slot 26
        g_chg = 100;
        run_cycles(0, 218);
        check_val("slot_before_mid_rst", 32'(bus_a.o_SLOT), 32'd26);

        // asynchronous reset between clock edges
        #2 ic_n = 1'b0;
        #1 check_reset("rst_mid");

        // second session: same release behaviour, resync after the 32-slot wrap
        g_chg = 100000;
        set_stb(stb_old[0], stb_old[1], stb_old[2], stb_old[3]);
        g_rs = 51;
        repeat (16) @(posedge clk);
        #3 check_reset("rst_mid_hold");
        ic_n = 1'b1;
        run_cycles(0, 90);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
